spi_module: RTL and testbench

// - 8-bit full-duplex SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// - Holds a TX buffer, a shift register (SSPSR) and an RX buffer, each moved by explicit strobes.
// - Sits between a register/CPU-side interface and one external SPI slave.
// - Exposes FSM state and shift register contents for debug.

---
 rtl/spi_module.sv | 126 ++++++++++++
 tb/tb_spi_module.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spi_module.sv
// 8-bit mode-0 SPI master with TX buffer, shift register (SSPSR) and RX buffer,
// each moved by explicit strobes; FSM state and SSPSR exposed for debug.
module spi_module #(
    parameter int unsigned HALF_BIT = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_en,
    input  logic       i_rx_en,
    input  logic [7:0] i_data_in,
    input  logic       i_spi_miso,
    input  logic       out_buf_w,
    input  logic       buf_psr_w,
    input  logic       buf_psr_r,
    input  logic       out_buf_r,
    output logic [7:0] o_data_out,
    output logic       o_tx_done,
    output logic       o_rx_done,
    output logic       o_spi_sck,
    output logic       o_spi_cs,
    output logic       o_spi_mosi,
    output logic [3:0] state,
    output logic       o_busy,
    output logic [7:0] sspsr
);

    localparam int unsigned CW = $clog2(2 * HALF_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * HALF_BIT - 1);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        BIT7 = 4'd1,
        BIT6 = 4'd2,
        BIT5 = 4'd3,
        BIT4 = 4'd4,
        BIT3 = 4'd5,
        BIT2 = 4'd6,
        BIT1 = 4'd7,
        BIT0 = 4'd8,
        DONE = 4'd9
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    sspsr_q, sspsr_d;
    logic [7:0]    txbuf_q, rxbuf_q, data_q;
    logic          cap_q, cap_d;
    logic          txl_q, txl_d, rxl_q, rxl_d;
    logic          in_bit, rx_bit;

    assign in_bit = (state_q >= BIT7) && (state_q <= BIT0);

    // MISO is taken live on the cycle SCK goes high and held in cap_q after that.
    assign rx_bit = (cnt_q == CNT_HALF) ? (i_spi_miso & i_rx_en) : cap_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sspsr_d = sspsr_q;
        cap_d   = cap_q;
        txl_d   = txl_q;
        rxl_d   = rxl_q;
        case (state_q)
            IDLE: begin
                if (buf_psr_w) begin
                    sspsr_d = txbuf_q;
                    cnt_d   = '0;
                    state_d = BIT7;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (in_bit) begin
                    if (cnt_q == CNT_HALF) cap_d = rx_bit;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        sspsr_d = {sspsr_q[6:0], rx_bit};
                        txl_d   = i_tx_en;
                        rxl_d   = i_rx_en;
                        state_d = (state_q == BIT0) ? DONE : state_e'(state_q + 4'd1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sspsr_q <= '0;
            txbuf_q <= '0;
            rxbuf_q <= '0;
            data_q  <= '0;
            cap_q   <= 1'b0;
            txl_q   <= 1'b0;
            rxl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sspsr_q <= sspsr_d;
            cap_q   <= cap_d;
            txl_q   <= txl_d;
            rxl_q   <= rxl_d;
            if (out_buf_w) txbuf_q <= i_data_in;
            if (buf_psr_r && (state_q == IDLE || state_q == DONE)) rxbuf_q <= sspsr_q;
            if (out_buf_r) data_q <= rxbuf_q;
        end
    end

    assign o_busy     = in_bit;
    assign o_spi_cs   = ~in_bit;
    assign o_spi_sck  = in_bit && (cnt_q >= CNT_HALF);
    assign o_spi_mosi = in_bit && i_tx_en && sspsr_q[7];
    assign o_tx_done  = (state_q == DONE) && txl_q;
    assign o_rx_done  = (state_q == DONE) && rxl_q;
    assign o_data_out = data_q;
    assign state      = state_q;
    assign sspsr      = sspsr_q;

endmodule

// File: tb/tb_spi_module.sv
// Directed bench for spi_module at HALF_BIT=1: bit-level MOSI/SCK/CS checks,
// buffer strobe ordering, enable gating, ignored mid-transfer strobes, async reset.
module tb_spi_module;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0, rx_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       miso = 1'b0;
  logic       obw = 1'b0, bpw = 1'b0, bpr = 1'b0, obr = 1'b0;
  logic [7:0] data_out, sspsr;
  logic       tx_done, rx_done, sck, cs, mosi, busy;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  spi_module #(.HALF_BIT(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_tx_en(tx_en), .i_rx_en(rx_en),
    .i_data_in(data_in), .i_spi_miso(miso),
    .out_buf_w(obw), .buf_psr_w(bpw), .buf_psr_r(bpr), .out_buf_r(obr),
    .o_data_out(data_out), .o_tx_done(tx_done), .o_rx_done(rx_done),
    .o_spi_sck(sck), .o_spi_cs(cs), .o_spi_mosi(mosi),
    .state(state), .o_busy(busy), .sspsr(sspsr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_tx(input logic [7:0] d);
    data_in = d; obw = 1'b1;
    tick();
    obw = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit);
    int unsigned n;
    n = 0;
    while (state !== 4'd9 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (state !== 4'd9) begin
      errors++;
      $error("FAIL wait_done expired after %0d cycles", limit);
    end
  endtask

  task automatic xfer(input logic [7:0] miso_w, input logic [7:0] exp_mosi,
                      input logic [7:0] exp_sspsr, input logic exp_txd, input logic exp_rxd,
                      input logic mid, input logic same_w, input logic [7:0] same_d);
    bpw = 1'b1;
    if (same_w) begin
      obw = 1'b1; data_in = same_d;
    end
    tick();
    bpw = 1'b0; obw = 1'b0;
    chk("start_cs", 8'(cs), 8'(1'b0));
    chk("start_busy", 8'(busy), 8'(1'b1));
    for (int unsigned i = 0; i < 8; i++) begin
      miso = miso_w[7-i];
      chk("bit_state", 8'(state), 8'(i + 1));
      chk("sck_low", 8'(sck), 8'(1'b0));
      chk("mosi_lo", 8'(mosi), 8'(exp_mosi[7-i]));
      if (mid && i == 3) begin
        bpw = 1'b1; bpr = 1'b1; obw = 1'b1; data_in = 8'h29;
      end
      tick();
      bpw = 1'b0; bpr = 1'b0; obw = 1'b0;
      chk("sck_high", 8'(sck), 8'(1'b1));
      chk("cs_low", 8'(cs), 8'(1'b0));
      chk("mosi_hi", 8'(mosi), 8'(exp_mosi[7-i]));
      chk("no_done", 8'(tx_done | rx_done), 8'(1'b0));
      if (i < 7) tick();
    end
    wait_done(1);
    chk("done_state", 8'(state), 8'd9);
    chk("done_cs", 8'(cs), 8'(1'b1));
    chk("done_sck", 8'(sck), 8'(1'b0));
    chk("done_mosi", 8'(mosi), 8'(1'b0));
    chk("done_busy", 8'(busy), 8'(1'b0));
    chk("tx_done", 8'(tx_done), 8'(exp_txd));
    chk("rx_done", 8'(rx_done), 8'(exp_rxd));
    chk("done_sspsr", sspsr, exp_sspsr);
    tick();
    chk("back_idle", 8'(state), 8'd0);
    chk("pulse_end", 8'(tx_done | rx_done), 8'(1'b0));
  endtask

  initial begin
    #200000;
    errors++;
    $error("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    tick();
    tick();
    chk("rst_cs", 8'(cs), 8'(1'b1));
    chk("rst_sck", 8'(sck), 8'(1'b0));
    chk("rst_mosi", 8'(mosi), 8'(1'b0));
    chk("rst_busy", 8'(busy), 8'(1'b0));
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_sspsr", sspsr, 8'h00);
    rst = 1'b0;
    tick();
    chk("idle_cs", 8'(cs), 8'(1'b1));

    tx_en = 1'b1; rx_en = 1'b1;
    write_tx(8'hAF);
    xfer(8'h5A, 8'hAF, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    bpr = 1'b1; tick(); bpr = 1'b0;
    obr = 1'b1; tick(); obr = 1'b0;
    chk("read_5a", data_out, 8'h5A);

    tx_en = 1'b0; rx_en = 1'b0;
    xfer(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    tx_en = 1'b1; rx_en = 1'b1;
    write_tx(8'hC3);
    xfer(8'h3C, 8'hC3, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    obr = 1'b1; tick(); obr = 1'b0;
    chk("rxbuf_kept", data_out, 8'h5A);
    bpr = 1'b1; obr = 1'b1; tick(); bpr = 1'b0; obr = 1'b0;
    chk("read_old_rx", data_out, 8'h5A);
    obr = 1'b1; tick(); obr = 1'b0;
    chk("read_3c", data_out, 8'h3C);

    xfer(8'h00, 8'h29, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81);
    xfer(8'hA5, 8'h81, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    write_tx(8'h66);
    bpw = 1'b1; tick(); bpw = 1'b0;
    for (int unsigned i = 0; i < 8; i++) tick();
    chk("at_bit3", 8'(state), 8'd5);
    #2 rst = 1'b1;
    #1;
    chk("arst_cs", 8'(cs), 8'(1'b1));
    chk("arst_sck", 8'(sck), 8'(1'b0));
    chk("arst_mosi", 8'(mosi), 8'(1'b0));
    chk("arst_busy", 8'(busy), 8'(1'b0));
    chk("arst_state", 8'(state), 8'd0);
    chk("arst_sspsr", sspsr, 8'h00);
    chk("arst_dout", data_out, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    write_tx(8'hA5);
    xfer(8'h96, 8'hA5, 8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    bpr = 1'b1; tick(); bpr = 1'b0;
    obr = 1'b1; tick(); obr = 1'b0;
    chk("read_96", data_out, 8'h96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
